// File: rtl/mq_pkg.sv
// Shared types and constants for the MQ coder control slice.
// Context numbering, initial Qe indices and FSM state encoding.
package mq_pkg;

    localparam int NUM_CTX = 19;

    localparam logic [3:0] CT_INIT = 4'd12;

    localparam logic [5:0] IDX_UNI = 6'd46;
    localparam logic [5:0] IDX_RL  = 6'd3;
    localparam logic [5:0] IDX_ZC0 = 6'd4;

    localparam logic [4:0] CX_ZC0  = 5'd0;
    localparam logic [4:0] CX_UNI  = 5'd17;
    localparam logic [4:0] CX_RL   = 5'd18;
    localparam logic [4:0] CX_LAST = 5'(NUM_CTX - 1);

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        FETCH,
        CODE,
        CT_UPD,
        BYTEOUT,
        FLUSH,
        DONE
    } state_t;

    // Segment-start Qe index of a context
    function automatic logic [5:0] init_idx(
        input logic [4:0] cx
    );
        logic [5:0] r;
        r = 6'd0;
        if (cx == CX_ZC0) r = IDX_ZC0;
        if (cx == CX_UNI) r = IDX_UNI;
        if (cx == CX_RL)  r = IDX_RL;
        return r;
    endfunction

endpackage

// File: rtl/mq_coder_ctrl_table.sv
// Per-context Qe index / MPS store.
// Init walk and coding write-back share one write port; read is registered.
module mq_ctx_table
    import mq_pkg::*;
(
    input  logic       clk,
    input  logic       init_en,
    input  logic [4:0] init_addr,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [5:0] wr_idx,
    input  logic       wr_mps,
    input  logic       rd_en,
    input  logic [4:0] rd_addr,
    output logic [5:0] rd_idx,
    output logic       rd_mps
);

    logic [5:0] idx_mem [NUM_CTX];
    logic       mps_mem [NUM_CTX];

    // Init walk has priority; it never overlaps a coding write
    always_ff @(posedge clk) begin
        if (init_en) begin
            idx_mem[init_addr] <= init_idx(init_addr);
            mps_mem[init_addr] <= 1'b0;
        end else if (wr_en) begin
            idx_mem[wr_addr] <= wr_idx;
            mps_mem[wr_addr] <= wr_mps;
        end
    end

    // Registered read, data valid the cycle after rd_en
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_idx <= idx_mem[rd_addr];
            rd_mps <= mps_mem[rd_addr];
        end
    end

endmodule

// File: rtl/mq_coder_ctrl.sv
// MQ coder control: context fetch, IU drive, CT renormalisation,
// byte-out sequencing and end-of-segment flush.
module mq_coder_ctrl
    import mq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [4:0] in_cx,
    input  logic       in_d,
    input  logic       in_last,
    output logic [5:0] pe_index,
    input  logic       pe_switch,
    output logic       mps_coding,
    output logic [5:0] qe_index_pre,
    output logic       iu_en,
    output logic       iu_flush,
    input  logic [3:0] iu_lz,
    input  logic [5:0] iu_sel_index,
    output logic       set_ct,
    output logic [3:0] ct,
    output logic       bo_req,
    output logic       bo_flush,
    input  logic       bo_ack,
    input  logic       bo_stuff,
    output logic       done
);

    state_t     state;
    logic [4:0] init_addr;
    logic [4:0] cx_q;
    logic       d_q;
    logic       last_q;
    logic       mps_q;
    logic [3:0] shift_rem;
    logic       fcnt;

    logic [4:0] rd_cx;
    logic       rd_en;
    logic [5:0] rd_idx;
    logic       rd_mps;
    logic       wr_mps;

    // Out-of-range contexts fold onto context 0
    assign rd_cx  = (in_cx <= CX_LAST) ? in_cx : CX_ZC0;
    assign rd_en  = (state == IDLE) && in_valid;
    assign wr_mps = mps_q ^ (~mps_coding & pe_switch);

    mq_ctx_table u_table (
        .clk       (clk),
        .init_en   (state == INIT),
        .init_addr (init_addr),
        .wr_en     (state == CODE),
        .wr_addr   (cx_q),
        .wr_idx    (iu_sel_index),
        .wr_mps    (wr_mps),
        .rd_en     (rd_en),
        .rd_addr   (rd_cx),
        .rd_idx    (rd_idx),
        .rd_mps    (rd_mps)
    );

    // Control FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= INIT;
            init_addr    <= 5'd0;
            in_ready     <= 1'b0;
            iu_en        <= 1'b0;
            iu_flush     <= 1'b1;
            bo_req       <= 1'b0;
            bo_flush     <= 1'b0;
            set_ct       <= 1'b0;
            done         <= 1'b0;
            ct           <= CT_INIT;
            pe_index     <= 6'd0;
            qe_index_pre <= 6'd0;
            mps_coding   <= 1'b0;
            cx_q         <= 5'd0;
            d_q          <= 1'b0;
            last_q       <= 1'b0;
            mps_q        <= 1'b0;
            shift_rem    <= 4'd0;
            fcnt         <= 1'b0;
        end else begin
            set_ct <= 1'b0;
            done   <= 1'b0;
            unique case (state)
                INIT: begin
                    iu_flush <= 1'b0;
                    if (init_addr == CX_LAST) begin
                        init_addr <= 5'd0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        init_addr <= init_addr + 5'd1;
                    end
                end
                IDLE: begin
                    if (in_valid) begin
                        cx_q     <= rd_cx;
                        d_q      <= in_d;
                        last_q   <= in_last;
                        in_ready <= 1'b0;
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    pe_index     <= rd_idx;
                    qe_index_pre <= rd_idx;
                    mps_q        <= rd_mps;
                    mps_coding   <= (d_q == rd_mps);
                    iu_en        <= 1'b1;
                    state        <= CODE;
                end
                CODE: begin
                    iu_en     <= 1'b0;
                    shift_rem <= iu_lz;
                    state     <= CT_UPD;
                end
                CT_UPD: begin
                    if (shift_rem < ct) begin
                        ct <= ct - shift_rem;
                        if (last_q) begin
                            bo_req   <= 1'b1;
                            bo_flush <= 1'b1;
                            fcnt     <= 1'b0;
                            state    <= FLUSH;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= IDLE;
                        end
                    end else begin
                        shift_rem <= shift_rem - ct;
                        ct        <= 4'd0;
                        bo_req    <= 1'b1;
                        state     <= BYTEOUT;
                    end
                end
                BYTEOUT: begin
                    if (bo_ack) begin
                        ct     <= bo_stuff ? 4'd7 : 4'd8;
                        set_ct <= 1'b1;
                        bo_req <= 1'b0;
                        state  <= CT_UPD;
                    end
                end
                FLUSH: begin
                    if (bo_req && bo_ack) begin
                        bo_req <= 1'b0;
                        if (fcnt) begin
                            bo_flush <= 1'b0;
                            done     <= 1'b1;
                            iu_flush <= 1'b1;
                            ct       <= CT_INIT;
                            set_ct   <= 1'b1;
                            state    <= DONE;
                        end else begin
                            fcnt <= 1'b1;
                        end
                    end else if (!bo_req) begin
                        bo_req <= 1'b1;
                    end
                end
                DONE: begin
                    iu_flush  <= 1'b0;
                    init_addr <= 5'd0;
                    state     <= INIT;
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_mq_coder_ctrl.sv
// Directed bench for mq_coder_ctrl with a byte-out responder.
// Expected values are hand-derived from the coder behaviour.
module tb_mq_coder_ctrl;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_cx;
    logic       in_d;
    logic       in_last;
    logic [5:0] pe_index;
    logic       pe_switch;
    logic       mps_coding;
    logic [5:0] qe_index_pre;
    logic       iu_en;
    logic       iu_flush;
    logic [3:0] iu_lz;
    logic [5:0] iu_sel_index;
    logic       set_ct;
    logic [3:0] ct;
    logic       bo_req;
    logic       bo_flush;
    logic       bo_ack;
    logic       bo_stuff;
    logic       done;

    mq_coder_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_cx        (in_cx),
        .in_d         (in_d),
        .in_last      (in_last),
        .pe_index     (pe_index),
        .pe_switch    (pe_switch),
        .mps_coding   (mps_coding),
        .qe_index_pre (qe_index_pre),
        .iu_en        (iu_en),
        .iu_flush     (iu_flush),
        .iu_lz        (iu_lz),
        .iu_sel_index (iu_sel_index),
        .set_ct       (set_ct),
        .ct           (ct),
        .bo_req       (bo_req),
        .bo_flush     (bo_flush),
        .bo_ack       (bo_ack),
        .bo_stuff     (bo_stuff),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;
    int n_bo = 0;
    int n_fl = 0;
    int n_set = 0;
    int n_done = 0;
    int n_dfl = 0;
    int lat;
    int cap_idx;
    int cap_pre;
    int cap_mc;
    int b0;
    int s0;
    int n;
    logic auto_ack = 1'b1;
    logic stuff_val = 1'b0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Byte-out responder: one-cycle ack per request
    initial begin
        bo_ack = 1'b0;
        bo_stuff = 1'b0;
        forever begin
            @(negedge clk);
            if (auto_ack && bo_req && !bo_ack) begin
                bo_ack = 1'b1;
                bo_stuff = stuff_val;
                n_bo++;
                if (bo_flush) n_fl++;
            end else begin
                bo_ack = 1'b0;
            end
        end
    end

    // Pulse counters, sampled just before each edge
    initial forever begin
        @(posedge clk);
        if (set_ct) n_set++;
        if (done) begin
            n_done++;
            if (iu_flush) n_dfl++;
        end
    end

    task automatic count_init(output int cnt);
        cnt = 0;
        while (!in_ready && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic send(
        input logic [4:0] cx,
        input logic       d,
        input logic       last,
        input logic [3:0] lz,
        input logic [5:0] sel,
        input logic       sw
    );
        int w;
        w = 0;
        while (!in_ready && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) chk("ready_timeout", 0, 1);
        in_cx = cx;
        in_d = d;
        in_last = last;
        iu_lz = lz;
        iu_sel_index = sel;
        pe_switch = sw;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        cap_idx = -1;
        cap_pre = -1;
        cap_mc = -1;
        while (lat < 400) begin
            if (iu_en) begin
                cap_idx = int'(pe_index);
                cap_pre = int'(qe_index_pre);
                cap_mc = int'(mps_coding);
            end
            if (in_ready || done || (!auto_ack && bo_req)) break;
            @(negedge clk);
            lat++;
        end
        if (lat >= 400) chk("symbol_timeout", 0, 1);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_cx = 5'd0;
        in_d = 1'b0;
        in_last = 1'b0;
        pe_switch = 1'b0;
        iu_lz = 4'd0;
        iu_sel_index = 6'd0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_iu_flush", int'(iu_flush), 1);
        chk("rst_ct", int'(ct), 12);
        chk("rst_bo_req", int'(bo_req), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pe_index", int'(pe_index), 0);
        rst = 1'b0;
        count_init(n);
        chk("init_cycles", n, 19);
        chk("init_iu_flush", int'(iu_flush), 0);

        send(5'd17, 1'b0, 1'b0, 4'd0, 6'd46, 1'b0);
        chk("cx17_idx", cap_idx, 46);
        chk("cx17_mps", cap_mc, 1);
        send(5'd18, 1'b0, 1'b0, 4'd0, 6'd3, 1'b0);
        chk("cx18_idx", cap_idx, 3);
        send(5'd0, 1'b0, 1'b0, 4'd0, 6'd4, 1'b0);
        chk("cx0_idx", cap_idx, 4);
        send(5'd20, 1'b0, 1'b0, 4'd0, 6'd4, 1'b0);
        chk("cx20_idx", cap_idx, 4);
        chk("ct_lz0", int'(ct), 12);

        b0 = n_bo;
        send(5'd5, 1'b0, 1'b0, 4'd1, 6'd1, 1'b0);
        chk("cx5_idx0", cap_idx, 0);
        chk("cx5_pre0", cap_pre, 0);
        chk("cx5_mc0", cap_mc, 1);
        chk("latency", lat, 4);
        chk("ct_11", int'(ct), 11);
        chk("no_bo", n_bo, b0);

        send(5'd5, 1'b1, 1'b0, 4'd1, 6'd1, 1'b1);
        chk("cx5_idx1", cap_idx, 1);
        chk("lps_mc", cap_mc, 0);
        send(5'd5, 1'b1, 1'b0, 4'd1, 6'd1, 1'b0);
        chk("mps_flip", cap_mc, 1);
        send(5'd5, 1'b0, 1'b0, 4'd1, 6'd1, 1'b0);
        chk("lps2_mc", cap_mc, 0);
        send(5'd5, 1'b1, 1'b0, 4'd5, 6'd1, 1'b0);
        chk("mps_kept", cap_mc, 1);
        chk("ct_3", int'(ct), 3);

        b0 = n_bo;
        s0 = n_set;
        stuff_val = 1'b1;
        send(5'd6, 1'b0, 1'b0, 4'd3, 6'd0, 1'b0);
        chk("eq_bo", n_bo - b0, 1);
        chk("eq_set_ct", n_set - s0, 1);
        chk("ct_stuff7", int'(ct), 7);

        stuff_val = 1'b0;
        send(5'd6, 1'b0, 1'b0, 4'd5, 6'd0, 1'b0);
        chk("ct_2", int'(ct), 2);
        b0 = n_bo;
        s0 = n_set;
        send(5'd6, 1'b0, 1'b0, 4'd11, 6'd0, 1'b0);
        chk("two_bo", n_bo - b0, 2);
        chk("two_set_ct", n_set - s0, 2);
        chk("ct_after2", int'(ct), 7);

        b0 = n_fl;
        send(5'd6, 1'b0, 1'b1, 4'd0, 6'd0, 1'b0);
        chk("flush_done", int'(done), 1);
        chk("flush_iu", int'(iu_flush), 1);
        chk("flush_ct", int'(ct), 12);
        chk("flush_bytes", n_fl - b0, 2);
        @(negedge clk);
        count_init(n);
        chk("reinit_cycles", n, 19);
        chk("done_pulses", n_done, 1);
        chk("done_iu_flush", n_dfl, 1);
        send(5'd5, 1'b0, 1'b0, 4'd0, 6'd0, 1'b0);
        chk("cx5_reinit", cap_idx, 0);

        auto_ack = 1'b0;
        send(5'd6, 1'b0, 1'b0, 4'd12, 6'd0, 1'b0);
        chk("abort_req_up", int'(bo_req), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_bo_req", int'(bo_req), 0);
        chk("abort_ct", int'(ct), 12);
        chk("abort_ready", int'(in_ready), 0);
        rst = 1'b0;
        count_init(n);
        chk("abort_init", n, 19);
        chk("abort_no_done", n_done, 1);
        auto_ack = 1'b1;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
